// File: rtl/wrr_burst_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wrr_burst_arbiter_if
//  Description : Request/grant bundle between N channel masters and the
//                weighted round-robin burst arbiter.
//                  req     N      per-master request (level, held to end)
//                  weight  N*WW   per-master transaction budget per tenure
//                  last    1      final beat of the granted transaction
//                  gnt     N      registered one-hot grant (0 when idle)
//                  gnt_id  log2N  index of the granted master
//                  busy    1      |gnt
//                master modport : requester side (drives req/weight/last)
//                slave  modport : arbiter side (drives gnt/gnt_id/busy)
//  Revision    : 1.0  initial release
// ============================================================================
interface wrr_burst_arbiter_if #(
    parameter int N  = 4,
    parameter int WW = 3
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req;
    logic [N*WW-1:0] weight;
    logic            last;
    logic [N-1:0]    gnt;
    logic [IDW-1:0]  gnt_id;
    logic            busy;

    modport master (
        output req,
        output weight,
        output last,
        input  gnt,
        input  gnt_id,
        input  busy
    );

    modport slave (
        input  req,
        input  weight,
        input  last,
        output gnt,
        output gnt_id,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/wrr_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wrr_burst_arbiter
//  Description : Weighted round-robin arbiter for N masters sharing one
//                transaction channel. The grant is registered, one-hot and
//                held for a whole multi-beat transaction until 'last'. Each
//                master may run up to W(i) back-to-back transactions before
//                the grant rotates; handover between owners has no bubble.
//  Ports       : clk    - clock, all state updates on posedge
//                rst_n  - asynchronous active-low reset
//                bus    - slave modport of wrr_burst_arbiter_if
//                         (req, weight, last in; gnt, gnt_id, busy out)
//  Revision    : 1.0  initial release
// ============================================================================
module wrr_burst_arbiter #(
    parameter int N  = 4,
    parameter int WW = 3
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    wrr_burst_arbiter_if.slave     bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_GRANT = 1'b1;

    logic [0:0]     r_state;
    logic [N-1:0]   r_gnt;
    logic [IDW-1:0] r_gnt_id;
    logic [IDW-1:0] r_ptr;
    logic [WW-1:0]  r_credit;

    logic           w_found;
    logic [IDW-1:0] w_win;
    logic [WW-1:0]  w_wt;
    logic [WW-1:0]  w_credit_load;
    logic           w_own_req;
    logic           w_end;

    // Index reached k steps after base, wrapping modulo N.
    function automatic logic [IDW-1:0] f_wrap(input logic [IDW-1:0] base, input int k);
        return IDW'((int'(base) + k) % N);
    endfunction

    // Rotating search: ptr+1 first, ptr itself last. While a grant is held
    // ptr equals the owner, so the same search serves both idle pick and
    // end-of-tenure rotation.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!w_found && bus.req[f_wrap(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = f_wrap(r_ptr, k);
            end
        end
    end

    // Winner's weight; a zero field loads as 1 so credit never starts at 0.
    always_comb begin
        w_wt = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win == IDW'(i)) begin
                w_wt = bus.weight[i*WW +: WW];
            end
        end
        w_credit_load = (w_wt == '0) ? WW'(1) : w_wt;
    end

    // Owner's own request, selected through the one-hot grant.
    always_comb begin
        w_own_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_gnt[i]) begin
                w_own_req = bus.req[i];
            end
        end
    end

    // Tenure ends on the last allowed transaction or when the owner drops
    // its request (abort), whichever comes first.
    assign w_end = !w_own_req || (bus.last && (r_credit <= WW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= IDW'(N - 1);
            r_credit <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_state  <= c_GRANT;
                        r_gnt    <= N'(1) << w_win;
                        r_gnt_id <= w_win;
                        r_ptr    <= w_win;
                        r_credit <= w_credit_load;
                    end
                end
                c_GRANT: begin
                    if (w_end) begin
                        if (w_found) begin
                            r_gnt    <= N'(1) << w_win;
                            r_gnt_id <= w_win;
                            r_ptr    <= w_win;
                            r_credit <= w_credit_load;
                        end else begin
                            r_state  <= c_IDLE;
                            r_gnt    <= '0;
                            r_gnt_id <= '0;
                            r_credit <= '0;
                        end
                    end else if (bus.last) begin
                        r_credit <= r_credit - WW'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.gnt_id = r_gnt_id;
    assign bus.busy   = |r_gnt;
endmodule
`default_nettype wire

// File: tb/tb_wrr_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wrr_burst_arbiter
//  Description : Directed self-checking bench for wrr_burst_arbiter (N=4,
//                WW=3): reset, weighted rotation, self re-grant, wrap,
//                abort, non-preemption, zero weight, async reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wrr_burst_arbiter;
    localparam int N  = 4;
    localparam int WW = 3;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    wrr_burst_arbiter_if #(.N(N), .WW(WW)) bus ();

    wrr_burst_arbiter #(.N(N), .WW(WW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.last = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int seq [10] = '{0, 0, 0, 1, 1, 2, 3, 0, 0, 0};

    initial begin
        n_checks   = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        bus.req    = 4'b1111;
        bus.last   = 1'b0;
        bus.weight = {3'd1, 3'd1, 3'd2, 3'd3};

        // 1: reset with all requests high, then first grant to m0
        tick();
        chk("rst_gnt",    8'(bus.gnt),    8'h00);
        chk("rst_busy",   8'(bus.busy),   8'h00);
        chk("rst_gnt_id", 8'(bus.gnt_id), 8'h00);
        rst_n = 1'b1;
        tick();
        chk("first_gnt",  8'(bus.gnt),    8'h01);
        chk("first_busy", 8'(bus.busy),   8'h01);

        // 2: weights m0=3 m1=2 m2=1 m3=1, two-beat transactions, every beat checked
        for (int t = 0; t < 10; t++) begin
            chk($sformatf("wrr_beat0_t%0d", t), 8'(bus.gnt), 8'(1 << seq[t]));
            bus.last = 1'b0;
            tick();
            chk($sformatf("wrr_beat1_t%0d", t), 8'(bus.gnt), 8'(1 << seq[t]));
            bus.last = 1'b1;
            tick();
        end
        chk("wrr_after_id", 8'(bus.gnt_id), 8'h01);

        // 3: lone requester m2 with weight 1 re-grants itself without bubble
        do_reset();
        bus.weight = {3'd1, 3'd1, 3'd1, 3'd1};
        bus.req    = 4'b0100;
        tick();
        chk("solo_gnt", 8'(bus.gnt), 8'h04);
        bus.last = 1'b1;
        tick();
        chk("solo_regrant1", 8'(bus.gnt), 8'h04);
        tick();
        chk("solo_regrant2", 8'(bus.gnt), 8'h04);
        chk("solo_id",       8'(bus.gnt_id), 8'h02);
        bus.req = 4'b0000;
        tick();
        chk("solo_drop_gnt",  8'(bus.gnt),    8'h00);
        chk("solo_drop_busy", 8'(bus.busy),   8'h00);
        chk("solo_drop_id",   8'(bus.gnt_id), 8'h00);
        bus.last = 1'b0;
        tick();
        chk("idle_last_ignored", 8'(bus.gnt), 8'h00);

        // 4: owner m3 ends with req=1001 -> scan wraps to m0
        do_reset();
        bus.req = 4'b1000;
        tick();
        chk("wrap_own", 8'(bus.gnt), 8'h08);
        bus.req  = 4'b1001;
        bus.last = 1'b1;
        tick();
        chk("wrap_gnt", 8'(bus.gnt),    8'h01);
        chk("wrap_id",  8'(bus.gnt_id), 8'h00);

        // 5: abort by m1, then m0 must not preempt m2
        do_reset();
        bus.weight = {3'd1, 3'd1, 3'd3, 3'd1};
        bus.req    = 4'b0010;
        tick();
        chk("abort_own", 8'(bus.gnt), 8'h02);
        tick();
        chk("abort_hold", 8'(bus.gnt), 8'h02);
        bus.req = 4'b0100;
        tick();
        chk("abort_gnt", 8'(bus.gnt),    8'h04);
        chk("abort_id",  8'(bus.gnt_id), 8'h02);
        bus.req = 4'b0101;
        tick();
        chk("no_preempt", 8'(bus.gnt), 8'h04);
        bus.last = 1'b1;
        tick();
        chk("rotate_after_m2", 8'(bus.gnt), 8'h01);

        // 6: zero weight behaves as one; async reset mid-grant
        do_reset();
        bus.weight = {3'd1, 3'd1, 3'd1, 3'd0};
        bus.req    = 4'b0011;
        tick();
        chk("w0_gnt", 8'(bus.gnt), 8'h01);
        bus.last = 1'b1;
        tick();
        chk("w0_rotate", 8'(bus.gnt), 8'h02);
        bus.last = 1'b0;
        tick();
        chk("pre_async", 8'(bus.gnt), 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_gnt",  8'(bus.gnt),  8'h00);
        chk("async_busy", 8'(bus.busy), 8'h00);
        bus.req = 4'b0110;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_gnt", 8'(bus.gnt),    8'h02);
        chk("post_rst_id",  8'(bus.gnt_id), 8'h01);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
